// File: rtl/vga_pkg.sv
// Shared constants for the VGA sprite renderer: colours, default 640x480 timing,
// sprite geometry and the stock game bitmaps.
package vga_pkg;

    // Raster counters are 11 bits so sprite right/bottom edges never wrap
    localparam int unsigned CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    // Colours, RRRGGGBB
    localparam logic [7:0] BLACK = 8'h00;
    localparam logic [7:0] GREEN = 8'h1C;
    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] WHITE = 8'hFF;

    // Default 640x480 @ 60 Hz timing
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Sprite geometry
    localparam int unsigned DEF_NUM_SPRITES = 4;
    localparam int unsigned DEF_SPR_W       = 16;
    localparam int unsigned DEF_SPR_H       = 8;

    // Bitmaps: row r occupies bits [16r+15:16r], bit 0 of a row is the leftmost column
    localparam logic [127:0] PLAYER_BMP = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                           16'h7FFE, 16'h03C0, 16'h03C0, 16'h0180};
    localparam logic [127:0] INVADER_BMP = {16'h0810, 16'h1818, 16'h3FFC, 16'h7BDE,
                                            16'hFFFF, 16'h3FFC, 16'h1818, 16'h0C30};
    localparam logic [127:0] PROJECTILE_BMP = {16'h0180, 16'h0180, 16'h0180, 16'h0180,
                                               16'h0180, 16'h0180, 16'h0180, 16'h0180};

    // Drive level of a sync signal given whether it is active
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters, raw (undelayed) sync/enable decode and the per-frame load strobe.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic clk_pixel,
    input  logic arst,
    output cnt_t h_cnt,
    output cnt_t v_cnt,
    output logic hsync_act,
    output logic vsync_act,
    output logic de,
    output logic frame_tick
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS      = cnt_t'(H_ACTIVE);
    localparam cnt_t V_VIS      = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START   = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END     = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START   = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END     = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t h_cnt_q;
    cnt_t v_cnt_q;

    // Pixel and line counters; the line advances when the pixel counter wraps
    always_ff @(posedge clk_pixel) begin
        if (arst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_q <= '0;
            v_cnt_q <= (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
        end else begin
            h_cnt_q <= h_cnt_q + cnt_t'(1);
        end
    end

    assign h_cnt      = h_cnt_q;
    assign v_cnt      = v_cnt_q;
    assign hsync_act  = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign vsync_act  = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    assign de         = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    // First pixel of the first blank line: the frame that is being shown has fully left stage 0
    assign frame_tick = (h_cnt_q == '0) && (v_cnt_q == V_VIS);

endmodule

// File: rtl/vga_sprite_renderer.sv
// Sprite compositor: double-buffered sprite attributes latched once per frame and a
// two-stage pipeline (hit test, then priority colour select) aligned with the syncs.
module vga_sprite_renderer
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int unsigned SPR_W       = DEF_SPR_W,
    parameter int unsigned SPR_H       = DEF_SPR_H,
    parameter logic [7:0]  BG_COLOR    = BLACK
) (
    input  logic                               clk_pixel,
    input  logic                               arst,
    input  logic [10*NUM_SPRITES-1:0]          spr_x,
    input  logic [10*NUM_SPRITES-1:0]          spr_y,
    input  logic [NUM_SPRITES-1:0]             spr_en,
    input  logic [8*NUM_SPRITES-1:0]           spr_color,
    input  logic [NUM_SPRITES*SPR_W*SPR_H-1:0] spr_bitmap,
    output logic [7:0]                         vga_out,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               data_enable,
    output logic                               frame_tick
);

    localparam int unsigned BMP_BITS = SPR_W * SPR_H;
    localparam int unsigned ALL_BITS = NUM_SPRITES * BMP_BITS;
    localparam int unsigned IDX_W    = $clog2(ALL_BITS);

    cnt_t h_cnt, v_cnt;
    logic hsync_act, vsync_act, de_raw, load;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_pixel  (clk_pixel),
        .arst       (arst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .hsync_act  (hsync_act),
        .vsync_act  (vsync_act),
        .de         (de_raw),
        .frame_tick (load)
    );

    // Shadow copies of the sprite attributes
    logic [10*NUM_SPRITES-1:0] sh_x_q, sh_y_q;
    logic [NUM_SPRITES-1:0]    sh_en_q;
    logic [8*NUM_SPRITES-1:0]  sh_color_q;
    logic [ALL_BITS-1:0]       sh_bitmap_q;

    // Enables are cleared by reset so nothing shows before the first load
    always_ff @(posedge clk_pixel) begin
        if (arst) begin
            sh_en_q <= '0;
        end else if (load) begin
            sh_en_q <= spr_en;
        end
    end

    // Position, colour and bitmap only matter while enabled, so they need no reset
    always_ff @(posedge clk_pixel) begin
        if (load) begin
            sh_x_q      <= spr_x;
            sh_y_q      <= spr_y;
            sh_color_q  <= spr_color;
            sh_bitmap_q <= spr_bitmap;
        end
    end

    // Stage 1 next-state: per-slot bounding-box hit and the addressed bitmap bit
    logic [NUM_SPRITES-1:0] hit_d, bit_d;
    always_comb begin
        cnt_t        px, py, dx, dy;
        int unsigned idx;
        hit_d = '0;
        bit_d = '0;
        for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
            px       = cnt_t'(sh_x_q[10*s +: 10]);
            py       = cnt_t'(sh_y_q[10*s +: 10]);
            dx       = h_cnt - px;
            dy       = v_cnt - py;
            hit_d[s] = sh_en_q[s]
                    && (h_cnt >= px) && (h_cnt < px + cnt_t'(SPR_W))
                    && (v_cnt >= py) && (v_cnt < py + cnt_t'(SPR_H));
            idx      = s * BMP_BITS + 32'(dy) * SPR_W + 32'(dx);
            bit_d[s] = hit_d[s] ? sh_bitmap_q[IDX_W'(idx)] : 1'b0;
        end
    end

    logic [NUM_SPRITES-1:0] hit_q, bit_q;
    logic                   de_q1, hs_q1, vs_q1;

    // Stage 1 registers
    always_ff @(posedge clk_pixel) begin
        if (arst) begin
            hit_q <= '0;
            bit_q <= '0;
            de_q1 <= 1'b0;
            hs_q1 <= ~SYNC_POL;
            vs_q1 <= ~SYNC_POL;
        end else begin
            hit_q <= hit_d;
            bit_q <= bit_d;
            de_q1 <= de_raw;
            hs_q1 <= sync_level(hsync_act, SYNC_POL);
            vs_q1 <= sync_level(vsync_act, SYNC_POL);
        end
    end

    // Stage 2 next-state: lowest opaque slot wins, blanking forces black
    logic [7:0] pix_d;
    always_comb begin
        pix_d = BG_COLOR;
        for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
            if (hit_q[s] && bit_q[s]) begin
                pix_d = sh_color_q[8*s +: 8];
            end
        end
        if (!de_q1) begin
            pix_d = 8'h00;
        end
    end

    logic [7:0] pix_q;
    logic       de_q2, hs_q2, vs_q2;

    // Stage 2 registers drive the pins
    always_ff @(posedge clk_pixel) begin
        if (arst) begin
            pix_q <= 8'h00;
            de_q2 <= 1'b0;
            hs_q2 <= ~SYNC_POL;
            vs_q2 <= ~SYNC_POL;
        end else begin
            pix_q <= pix_d;
            de_q2 <= de_q1;
            hs_q2 <= hs_q1;
            vs_q2 <= vs_q1;
        end
    end

    assign vga_out     = pix_q;
    assign data_enable = de_q2;
    assign hsync       = hs_q2;
    assign vsync       = vs_q2;
    assign frame_tick  = load;

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Bench for vga_sprite_renderer. Uses a reduced raster (92x49 total, 64x40 visible) so
// several whole frames fit in a short run; sprite geometry stays at 16x8, 4 slots.
module tb_vga_sprite_renderer;

    localparam int HA = 64, HF = 8, HS = 12, HB = 8;
    localparam int VA = 40, VF = 3, VS = 2, VB = 4;
    localparam int HT = HA + HF + HS + HB;  // 92
    localparam int VT = VA + VF + VS + VB;  // 49
    localparam int FT = HT * VT;            // 4508
    localparam logic [7:0] BG = 8'h03;
    localparam logic [127:0] FULL = {128{1'b1}};

    logic         clk_pixel = 1'b0;
    logic         arst = 1'b1;
    logic [39:0]  spr_x = '0;
    logic [39:0]  spr_y = '0;
    logic [3:0]   spr_en = '0;
    logic [31:0]  spr_color = '0;
    logic [511:0] spr_bitmap = '0;
    logic [7:0]   vga_out;
    logic         hsync, vsync, data_enable, frame_tick;

    vga_sprite_renderer #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0), .NUM_SPRITES (4), .SPR_W (16), .SPR_H (8),
        .BG_COLOR (BG)
    ) dut (
        .clk_pixel   (clk_pixel),
        .arst        (arst),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_en      (spr_en),
        .spr_color   (spr_color),
        .spr_bitmap  (spr_bitmap),
        .vga_out     (vga_out),
        .hsync       (hsync),
        .vsync       (vsync),
        .data_enable (data_enable),
        .frame_tick  (frame_tick)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Clocks since the last reset edge; equals the DUT raster index
    int cyc = 0;
    always @(posedge clk_pixel) begin
        if (arst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    typedef struct {
        int         frame;
        int         x;
        int         y;
        logic [7:0] color;
        logic       de;
    } exp_t;
    exp_t sb[$];

    task automatic push(input int f, input int x, input int y, input logic [7:0] c);
        exp_t e;
        e.frame = f;
        e.x     = x;
        e.y     = y;
        e.de    = (x < HA) && (y < VA);
        e.color = e.de ? c : 8'h00;
        sb.push_back(e);
    endtask

    task automatic set_slot(input int s, input int x, input int y, input logic [7:0] c,
                            input logic en, input logic [127:0] bmp);
        spr_x[10*s +: 10]     = 10'(x);
        spr_y[10*s +: 10]     = 10'(y);
        spr_color[8*s +: 8]   = c;
        spr_en[s]             = en;
        spr_bitmap[128*s +: 128] = bmp;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    // Scoreboard monitor: output at clock k shows raster index k-2
    always @(negedge clk_pixel) begin
        int n, t;
        if (!arst && cyc >= 2 && sb.size() > 0) begin
            n = cyc - 2;
            t = sb[0].frame * FT + sb[0].y * HT + sb[0].x;
            if (n == t) begin
                check($sformatf("pix f%0d (%0d,%0d)", sb[0].frame, sb[0].x, sb[0].y),
                      32'(vga_out), 32'(sb[0].color));
                check($sformatf("de f%0d (%0d,%0d)", sb[0].frame, sb[0].x, sb[0].y),
                      32'(data_enable), 32'(sb[0].de));
                void'(sb.pop_front());
            end else if (n > t) begin
                check($sformatf("missed f%0d (%0d,%0d)", sb[0].frame, sb[0].x, sb[0].y),
                      32'(n), 32'(t));
                void'(sb.pop_front());
            end
        end
    end

    // Timing monitor: per-cycle sync/enable/tick shape, summarised once per frame
    int bad = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0, tk_cnt = 0;
    always @(negedge clk_pixel) begin
        int n, x, l;
        logic de_e, hs_e, vs_e, tk_e;
        if (arst) begin
            bad = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; tk_cnt = 0;
        end else if (cyc >= 2) begin
            n    = cyc - 2;
            x    = n % HT;
            l    = (n % FT) / HT;
            de_e = (x < HA) && (l < VA);
            hs_e = (x >= HA + HF) && (x < HA + HF + HS);
            vs_e = (l >= VA + VF) && (l < VA + VF + VS);
            tk_e = ((cyc % FT) == VA * HT);
            if (data_enable !== de_e) bad++;
            if (hsync !== !hs_e) bad++;
            if (vsync !== !vs_e) bad++;
            if (frame_tick !== tk_e) bad++;
            if (!data_enable && vga_out !== 8'h00) bad++;
            if (data_enable) de_cnt++;
            if (!hsync) hs_cnt++;
            if (!vsync) vs_cnt++;
            if (frame_tick) tk_cnt++;
            if ((n % FT) == FT - 1) begin
                check($sformatf("timing bad cycles f%0d", n / FT), 32'(bad), 32'd0);
                check($sformatf("de cycles f%0d", n / FT), 32'(de_cnt), 32'd2560);
                check($sformatf("hsync low f%0d", n / FT), 32'(hs_cnt), 32'd588);
                check($sformatf("vsync low f%0d", n / FT), 32'(vs_cnt), 32'd184);
                check($sformatf("frame_tick f%0d", n / FT), 32'(tk_cnt), 32'd1);
                bad = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; tk_cnt = 0;
            end
        end
    end

    initial begin
        // Config A is live before reset release but must not show until the first load
        set_slot(0, 10, 5, 8'h1C, 1'b1, FULL);
        set_slot(1, 30, 20, 8'hE0, 1'b0, FULL);
        push(0, 10, 5, BG);  push(0, 17, 8, BG);
        push(1, 10, 4, BG);  push(1, 9, 5, BG);    push(1, 10, 5, 8'h1C);
        push(1, 25, 5, 8'h1C); push(1, 26, 5, BG); push(1, 17, 8, 8'h1C);
        push(1, 10, 12, 8'h1C); push(1, 25, 12, 8'h1C); push(1, 10, 13, BG);
        push(1, 30, 20, BG); push(1, 64, 20, 8'h00);
        repeat (3) @(posedge clk_pixel);
        #1 arst = 1'b0;

        // B: overlap, slot 0 row 0 and column 15 transparent over slot 1
        wait_cyc(1 * FT + 10 * HT);
        set_slot(0, 20, 20, 8'h1C, 1'b1, {{7{16'h7FFF}}, 16'h0000});
        set_slot(1, 20, 20, 8'hE0, 1'b1, FULL);
        push(2, 10, 5, BG);   push(2, 20, 20, 8'hE0); push(2, 35, 20, 8'hE0);
        push(2, 20, 21, 8'h1C); push(2, 34, 21, 8'h1C); push(2, 35, 21, 8'hE0);
        push(2, 36, 21, BG);  push(2, 34, 27, 8'h1C); push(2, 35, 27, 8'hE0);
        push(2, 20, 28, BG);

        // C: right-edge and bottom-edge clipping, slots 0/1 disabled
        wait_cyc(2 * FT + 10 * HT);
        set_slot(0, 20, 20, 8'h1C, 1'b0, FULL);
        set_slot(1, 20, 20, 8'hE0, 1'b0, FULL);
        set_slot(2, 56, 30, 8'hFF, 1'b1, FULL);
        set_slot(3, 40, 36, 8'hE0, 1'b1, FULL);
        push(3, 40, 0, BG);   push(3, 20, 20, BG);  push(3, 0, 30, BG);
        push(3, 7, 30, BG);   push(3, 20, 30, BG);  push(3, 55, 30, BG);
        push(3, 56, 30, 8'hFF); push(3, 63, 30, 8'hFF); push(3, 40, 39, 8'hE0);
        push(3, 55, 39, 8'hE0);

        // D: move slot 2 mid-frame; frame 3 checks above must still see the old position
        wait_cyc(3 * FT + 10 * HT);
        set_slot(2, 20, 30, 8'hFF, 1'b1, FULL);
        push(4, 19, 30, BG);  push(4, 20, 30, 8'hFF); push(4, 35, 30, 8'hFF);
        push(4, 36, 30, BG);  push(4, 56, 30, BG);    push(4, 40, 39, 8'hE0);

        wait_cyc(5 * FT);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        // One-cycle reset in the middle of a visible line
        wait_cyc(5 * FT + 5 * HT + 30);
        check("de before reset", 32'(data_enable), 32'd1);
        arst = 1'b1;
        @(posedge clk_pixel);
        #1;
        check("reset vga_out", 32'(vga_out), 32'h00);
        check("reset data_enable", 32'(data_enable), 32'd0);
        check("reset hsync", 32'(hsync), 32'd1);
        check("reset vsync", 32'(vsync), 32'd1);
        check("reset frame_tick", 32'(frame_tick), 32'd0);
        push(0, 0, 0, BG);    push(0, 20, 30, BG);  push(0, 40, 39, BG);
        push(1, 20, 30, 8'hFF); push(1, 40, 39, 8'hE0);
        arst = 1'b0;

        wait_cyc(2 * FT + 4);
        check("scoreboard drained after reset", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
